// File: rtl/sample_framer_if.sv
// Sample-framer handshake bundle.
//   recv_msg/recv_val/recv_rdy : streamed sample input, valid/ready handshake
//   send_msg/send_val/send_rdy : lane-parallel frame output, valid/ready handshake
// Modport master is the framer's view; slave is the view of the
// environment that feeds samples and consumes frames.
interface sample_framer_if #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8
);
  logic [BIT_WIDTH-1:0]                recv_msg;
  logic                                recv_val;
  logic                                recv_rdy;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg;
  logic                                send_val;
  logic                                send_rdy;

  modport master (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val
  );

  modport slave (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val
  );
endinterface

// File: rtl/sample_framer.sv
// Sample framer: collects N_SAMPLES streamed samples into a ping-pong pair of
// banks and presents each completed bank as one lane-parallel frame.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   io         : sample_framer_if.master (recv_* sample stream, send_* frame)
//   fill_count : samples held in the partially filled write bank
// BIT_REVERSE=1 presents lane k from bank slot bitrev(k).
module sample_framer #(
  parameter int unsigned BIT_WIDTH   = 32,
  parameter int unsigned N_SAMPLES   = 8,
  parameter int unsigned BIT_REVERSE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  sample_framer_if.master              io,
  output logic [$clog2(N_SAMPLES)-1:0] fill_count
);

  localparam int unsigned IDX_W = $clog2(N_SAMPLES);

  logic [1:0][N_SAMPLES-1:0][BIT_WIDTH-1:0] bank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;

  logic wr_fire;
  logic wr_last;
  logic rd_fire;

  function automatic logic [IDX_W-1:0] lane_src(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] r;
    r = k;
    if (BIT_REVERSE != 0) begin
      for (int unsigned i = 0; i < IDX_W; i++) begin
        r[i] = k[IDX_W-1-i];
      end
    end
    return r;
  endfunction

  // Ready and valid depend only on registered flags, so there is no
  // combinational path between the two handshakes.
  assign io.recv_rdy = ~full[wr_bank];
  assign io.send_val = full[rd_bank];
  assign fill_count  = wr_idx;

  assign wr_fire = io.recv_val & io.recv_rdy;
  assign wr_last = (wr_idx == IDX_W'(N_SAMPLES - 1));
  assign rd_fire = io.send_val & io.send_rdy;

  always_comb begin
    io.send_msg = '0;
    for (int unsigned k = 0; k < N_SAMPLES; k++) begin
      io.send_msg[k] = bank[rd_bank][lane_src(IDX_W'(k))];
    end
  end

  // A fill completes only into a non-full bank and a drain only empties a
  // full one, so the two updates always target different banks and both
  // can take effect on the same edge.
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_fire)            full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank    <= '0;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      if (wr_fire) begin
        bank[wr_bank][wr_idx] <= io.recv_msg;
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
      if (rd_fire) rd_bank <= ~rd_bank;
      full <= full_nxt;
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: a negedge monitor keeps a reference model of the
// framer (queue of completed frames plus the partial frame) and compares
// send_val, recv_rdy, fill_count and the head frame every cycle.
module tb_sample_framer;

  localparam int unsigned BW = 32;
  localparam int unsigned NS = 8;
  localparam int unsigned FW = NS * BW;

  typedef logic [NS-1:0][BW-1:0] frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] fill1;
  logic [2:0] fill2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  frame_t      exp_q[$];
  frame_t      part = '0;
  int unsigned part_cnt = 0;

  sample_framer_if #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) if1 ();
  sample_framer_if #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) if2 ();

  sample_framer #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .BIT_REVERSE(0)) dut (
    .clk(clk), .reset(reset), .io(if1.master), .fill_count(fill1)
  );

  sample_framer #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .BIT_REVERSE(1)) dut_rev (
    .clk(clk), .reset(reset), .io(if2.master), .fill_count(fill2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit which, input logic [BW-1:0] v);
    bit          acc;
    int unsigned budget;
    budget = 0;
    acc = 1'b0;
    if (which) begin if2.recv_val = 1'b1; if2.recv_msg = v; end
    else       begin if1.recv_val = 1'b1; if1.recv_msg = v; end
    while (!acc && budget < 200) begin
      acc = which ? if2.recv_rdy : if1.recv_rdy;
      tick();
      budget++;
    end
    check("push_timeout", FW'(acc), FW'(1));
    if (which) if2.recv_val = 1'b0;
    else       if1.recv_val = 1'b0;
  endtask

  task automatic wait_empty();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_timeout", FW'(exp_q.size()), FW'(0));
  endtask

  // Reference model: compare first, then apply the transfers that the
  // coming rising edge will perform.
  always @(negedge clk) begin : mon
    int unsigned n;
    if (!reset) begin
      exp_q.delete();
      part     = '0;
      part_cnt = 0;
    end else begin
      n = exp_q.size();
      check("send_val", FW'(if1.send_val), FW'(n > 0));
      check("recv_rdy", FW'(if1.recv_rdy), FW'(n < 2));
      check("fill_count", FW'(fill1), FW'(part_cnt));
      if (n > 0) begin
        check("send_msg", if1.send_msg, exp_q[0]);
        if (if1.send_rdy) void'(exp_q.pop_front());
      end
      if (if1.recv_val && n < 2) begin
        part[part_cnt[2:0]] = if1.recv_msg;
        part_cnt++;
        if (part_cnt == NS) begin
          exp_q.push_back(part);
          part_cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned rev_exp [NS];
    rev_exp = '{0, 4, 2, 6, 1, 5, 3, 7};

    if1.recv_val = 1'b0; if1.recv_msg = '0; if1.send_rdy = 1'b0;
    if2.recv_val = 1'b0; if2.recv_msg = '0; if2.send_rdy = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_send_val", FW'(if1.send_val), FW'(0));
    check("rst_recv_rdy", FW'(if1.recv_rdy), FW'(1));
    check("rst_fill", FW'(fill1), FW'(0));
    check("rst_send_msg", if1.send_msg, FW'(0));
    reset = 1'b1;

    // Bit-reversed lane order on the second instance
    for (int unsigned v = 0; v < NS; v++) push(1'b1, BW'(v));
    tick();
    check("rev_send_val", FW'(if2.send_val), FW'(1));
    check("rev_fill", FW'(fill2), FW'(0));
    for (int unsigned k = 0; k < NS; k++)
      check($sformatf("rev_lane%0d", k), FW'(if2.send_msg[k]), FW'(rev_exp[k]));

    // Back-to-back frame with an always-ready sink
    if1.send_rdy = 1'b1;
    for (int unsigned v = 1; v <= 8; v++) push(1'b0, BW'(v));
    repeat (3) tick();

    // Fill both banks with the sink stalled, then one-cycle drain
    if1.send_rdy = 1'b0;
    for (int unsigned v = 1; v <= 16; v++) push(1'b0, BW'(v));
    check("both_full_rdy", FW'(if1.recv_rdy), FW'(0));
    if1.recv_val = 1'b1;
    if1.recv_msg = 32'd17;
    repeat (3) tick();
    check("stalled_fill", FW'(fill1), FW'(0));
    if1.send_rdy = 1'b1;
    tick();
    if1.send_rdy = 1'b0;
    check("after_drain_rdy", FW'(if1.recv_rdy), FW'(1));
    check("after_drain_val", FW'(if1.send_val), FW'(1));
    check("after_drain_lane0", FW'(if1.send_msg[0]), FW'(9));
    check("after_drain_lane7", FW'(if1.send_msg[7]), FW'(16));

    // Stalled sink for 10 cycles while recv_val toggles
    for (int unsigned i = 0; i < 10; i++) begin
      if1.recv_val = (i % 2 == 0);
      if1.recv_msg = BW'(18 + i);
      tick();
    end
    if1.recv_val = 1'b0;
    if1.send_rdy = 1'b1;
    wait_empty();

    // Clean restart
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // 24 samples with random bubbles, always-ready sink
    if1.send_rdy = 1'b1;
    for (int unsigned v = 1; v <= 24; v++) begin
      while ($urandom_range(0, 2) == 0) begin
        if1.recv_val = 1'b0;
        tick();
      end
      push(1'b0, BW'(32'h1000 + v));
    end
    wait_empty();
    check("bubbles_fill", FW'(fill1), FW'(0));

    // Asynchronous reset with one full frame pending and a partial frame
    if1.send_rdy = 1'b0;
    for (int unsigned v = 0; v < 8; v++) push(1'b0, BW'(200 + v));
    for (int unsigned v = 0; v < 5; v++) push(1'b0, BW'(300 + v));
    check("pre_rst_fill", FW'(fill1), FW'(5));
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_send_val", FW'(if1.send_val), FW'(0));
    check("async_rst_fill", FW'(fill1), FW'(0));
    check("async_rst_recv_rdy", FW'(if1.recv_rdy), FW'(1));
    check("async_rst_send_msg", if1.send_msg, FW'(0));
    tick();
    reset = 1'b1;
    if1.send_rdy = 1'b1;
    for (int unsigned v = 100; v <= 107; v++) push(1'b0, BW'(v));
    wait_empty();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001: Parameter BIT_WIDTH, default 32, width of one sample.
REQ-002: Parameter N_SAMPLES, default 8, samples per frame; power of two, >= 2.
REQ-003: Parameter BIT_REVERSE, default 0; 1 = frame lanes presented in bit-reversed order.
REQ-004: clk  input  1  sole clock; all state updates on rising edge.
REQ-005: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006: recv_msg  input  BIT_WIDTH  one streamed sample.
REQ-007: recv_val  input  1  recv_msg valid.
REQ-008: recv_rdy  output  1  framer can accept a sample this cycle.
REQ-009: send_msg  output  array [N_SAMPLES-1:0] of BIT_WIDTH  one complete frame, lane-parallel.
REQ-010: send_val  output  1  complete frame presented on send_msg.
REQ-011: send_rdy  input  1  downstream FFT accepts the frame.
REQ-012: fill_count  output  $clog2(N_SAMPLES)  samples held in the partially filled write bank.

Function
REQ-013: Storage is two banks (0, 1) of N_SAMPLES x BIT_WIDTH registers, each with a full flag, plus wr_bank, rd_bank and wr_idx registers.
REQ-014: recv_rdy = !full[wr_bank], combinational from registered state only; no dependence on send_rdy.
REQ-015: A sample transfer occurs on a rising edge with recv_val && recv_rdy; the sample is written to bank[wr_bank][wr_idx] and wr_idx increments.
REQ-016: On the transfer with wr_idx == N_SAMPLES-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0 (wrap).
REQ-017: send_val = full[rd_bank]; send_msg lane k = bank[rd_bank][k] when BIT_REVERSE=0, = bank[rd_bank][bitrev(k)] when BIT_REVERSE=1.
REQ-018: A frame transfer occurs with send_val && send_rdy; full[rd_bank] <= 0 and rd_bank toggles; bank contents are not cleared.
REQ-019: send_msg and send_val SHALL remain stable while send_val=1 and send_rdy=0.
REQ-020: Latency: frame completing on edge t raises send_val after edge t (visible in cycle t+1); no same-cycle bypass from recv to send.
REQ-021: Simultaneous frame completion (one bank) and frame drain (other bank) on the same edge SHALL both take effect.
REQ-022: Both banks full: recv_rdy=0; a drain on edge t reasserts recv_rdy in cycle t+1, not in cycle t.
REQ-023: Sustained throughput SHALL be one sample per cycle when the sink accepts each frame within N_SAMPLES cycles of send_val rising.
REQ-024: recv_val=0 cycles (bubbles) SHALL neither advance wr_idx nor alter stored data.
REQ-025: fill_count = wr_idx.

Reset
REQ-026: While reset=0: both full flags 0, wr_bank=0, rd_bank=0, wr_idx=0, all bank registers 0; therefore send_val=0, send_msg all lanes 0, fill_count=0, recv_rdy=1.
REQ-027: Reset asserted mid-frame SHALL discard the partial frame and any undelivered full frames immediately (asynchronously).
REQ-028: First transfer after reset release SHALL occur no earlier than the first rising edge with reset=1.

Verification (N_SAMPLES=8, BIT_WIDTH=32)
REQ-029: Stream 1..8 on consecutive cycles, send_rdy=1 -> send_val high cycle after 8th sample, send_msg lanes 0..7 = 1..8, frame consumed in one cycle, recv_rdy never low.
REQ-030: BIT_REVERSE=1, stream 0..7 -> send_msg lanes = 0,4,2,6,1,5,3,7.
REQ-031: send_rdy=0, stream 16 samples 1..16 -> send_val=1 after 8th, recv_rdy=0 after 16th, 17th sample stalled; raise send_rdy one cycle -> frame 1..8 delivered, next cycle send_val=1 with 9..16, recv_rdy=1.
REQ-032: Continuous 24-sample stream with send_rdy=1 and random recv_val bubbles -> three frames delivered in order, no sample lost or duplicated, fill_count tracks wr_idx 0..7 wrap.
REQ-033: Assert reset after 5 of 8 samples and with one full frame pending -> send_val=0, fill_count=0, recv_rdy=1 immediately; next 8 samples 100..107 form first delivered frame.
REQ-034: Hold send_rdy=0 with send_val=1 for 10 cycles while recv_val toggles -> send_msg unchanged throughout.
